// File: rtl/alu_md_control_pkg.sv
// Shared definitions for the ALU control decoder and the multiply/divide
// sequencer: ALUOp values, funct/opcode values, ALU control codes, FSM encoding.
package alu_md_control_pkg;

    // ALUOp values driven by main control
    localparam logic [5:0] ALUOP_ADD   = 6'b000000;
    localparam logic [5:0] ALUOP_SUB   = 6'b000001;
    localparam logic [5:0] ALUOP_RTYPE = 6'b000010;

    // I-type opcodes forwarded on the ALUOp bus
    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_SLTIU = 6'b001011;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;

    // R-type funct values
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    // ALU control codes
    localparam logic [3:0] CTL_AND   = 4'b0000;
    localparam logic [3:0] CTL_OR    = 4'b0001;
    localparam logic [3:0] CTL_ADD   = 4'b0010;
    localparam logic [3:0] CTL_XOR   = 4'b0011;
    localparam logic [3:0] CTL_ADDU  = 4'b0100;
    localparam logic [3:0] CTL_SUBU  = 4'b0101;
    localparam logic [3:0] CTL_SUB   = 4'b0110;
    localparam logic [3:0] CTL_SLT   = 4'b0111;
    localparam logic [3:0] CTL_MULT  = 4'b1000;
    localparam logic [3:0] CTL_MULTU = 4'b1001;
    localparam logic [3:0] CTL_SLTU  = 4'b1010;
    localparam logic [3:0] CTL_DIV   = 4'b1011;
    localparam logic [3:0] CTL_DIVU  = 4'b1100;
    localparam logic [3:0] CTL_MFHI  = 4'b1101;
    localparam logic [3:0] CTL_MFLO  = 4'b1110;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } md_state_e;

    // Operation kind, equal to funct[1:0] of the four md instructions
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_kind_e;

    // True for the four funct codes handled by the sequencer
    function automatic logic is_md_funct(input logic [5:0] f);
        logic r;
        case (f)
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    // True for the HI/LO read instructions
    function automatic logic is_hl_funct(input logic [5:0] f);
        logic r;
        case (f)
            FN_MFHI, FN_MFLO: r = 1'b1;
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_md_control_md_seq_core.sv
// Multi-cycle radix-2 multiply/divide sequencer: operand capture, W
// shift-add / restoring shift-subtract steps, sign fix-up and HI/LO update.
module md_seq_core
    import alu_md_control_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  md_kind_e     kind,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    md_state_e        state_r;
    md_state_e        state_nxt_s;
    logic [CNT_W-1:0] count_r;
    logic [2*W-1:0]   acc_r;
    logic [W-1:0]     opnd_r;
    logic             is_div_r;
    logic             neg_res_r;
    logic             neg_rem_r;
    logic [W-1:0]     hi_r;
    logic [W-1:0]     lo_r;
    logic             done_r;

    logic             sign_op_s;
    logic             div_op_s;
    logic [W-1:0]     a_mag_s;
    logic [W-1:0]     b_mag_s;
    logic [W:0]       mul_sum_s;
    logic [W:0]       div_shift_s;
    logic [W:0]       div_diff_s;
    logic [2*W-1:0]   acc_step_s;
    logic [2*W-1:0]   prod_s;
    logic [W-1:0]     hi_fix_s;
    logic [W-1:0]     lo_fix_s;

    // Two's complement negate at operand width
    function automatic logic [W-1:0] negate(input logic [W-1:0] v);
        return (~v) + W'(1);
    endfunction

    // Absolute value for signed operations, raw value otherwise
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic use_sign);
        logic [W-1:0] r;
        if (use_sign && v[W-1]) begin
            r = negate(v);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Operand conditioning on the accept cycle
    always_comb begin
        sign_op_s = (kind == MD_MULT) || (kind == MD_DIV);
        div_op_s  = (kind == MD_DIV)  || (kind == MD_DIVU);
        a_mag_s   = magnitude(a, sign_op_s);
        b_mag_s   = magnitude(b, sign_op_s);
    end

    // One radix-2 step: acc = {high half, low half}; multiply consumes the
    // multiplier from the low half, divide shifts the dividend out of it and
    // quotient bits into it while the high half holds the partial remainder.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, opnd_r} : {(W+1){1'b0}});
        div_shift_s = {acc_r[2*W-1:W], acc_r[W-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        if (is_div_r) begin
            if (!div_diff_s[W]) begin
                acc_step_s = {div_diff_s[W-1:0], acc_r[W-2:0], 1'b1};
            end else begin
                acc_step_s = {div_shift_s[W-1:0], acc_r[W-2:0], 1'b0};
            end
        end else begin
            acc_step_s = {mul_sum_s, acc_r[W-1:1]};
        end
    end

    // Sign fix-up of the finished magnitudes
    always_comb begin
        prod_s = neg_res_r ? ((~acc_r) + (2*W)'(1)) : acc_r;
        if (is_div_r) begin
            lo_fix_s = neg_res_r ? negate(acc_r[W-1:0]) : acc_r[W-1:0];
            hi_fix_s = neg_rem_r ? negate(acc_r[2*W-1:W]) : acc_r[2*W-1:W];
        end else begin
            lo_fix_s = prod_s[W-1:0];
            hi_fix_s = prod_s[2*W-1:W];
        end
    end

    // Next-state logic for the IDLE -> RUN -> FIX -> IDLE sequence
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (count_r == CNT_W'(1)) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FIX:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath registers: capture, iterate, write back HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r   <= '0;
            acc_r     <= '0;
            opnd_r    <= '0;
            is_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            hi_r      <= '0;
            lo_r      <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        count_r   <= CNT_W'(W);
                        acc_r     <= {{W{1'b0}}, (div_op_s ? a_mag_s : b_mag_s)};
                        opnd_r    <= div_op_s ? b_mag_s : a_mag_s;
                        is_div_r  <= div_op_s;
                        neg_res_r <= sign_op_s && (a[W-1] ^ b[W-1]);
                        neg_rem_r <= sign_op_s && a[W-1];
                    end else begin
                        count_r   <= count_r;
                    end
                end
                ST_RUN: begin
                    acc_r   <= acc_step_s;
                    count_r <= count_r - CNT_W'(1);
                end
                ST_FIX: begin
                    hi_r <= hi_fix_s;
                    lo_r <= lo_fix_s;
                end
                default: begin
                    count_r <= '0;
                end
            endcase
        end
    end

    // Completion pulse in the cycle after HI/LO are written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r <= 1'b0;
        end else begin
            done_r <= (state_r == ST_FIX);
        end
    end

    assign busy = (state_r != ST_IDLE);
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: rtl/alu_md_control.sv
// ALU control decoder with multiply/divide sequencer and pipeline stall
// handshake for md and HI/LO read instructions.
module alu_md_control
    import alu_md_control_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid,
    input  logic [5:0]   op,
    input  logic [5:0]   funct,
    input  logic [W-1:0] rs_val,
    input  logic [W-1:0] rt_val,
    output logic [3:0]   control,
    output logic         stall,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         md_busy,
    output logic         md_done
);

    logic       md_op_s;
    logic       hl_rd_s;
    logic       busy_s;
    logic [3:0] control_s;

    // ALUOp/funct to ALU control code
    always_comb begin
        control_s = CTL_AND;
        case (op)
            ALUOP_ADD: control_s = CTL_ADD;
            ALUOP_SUB: control_s = CTL_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FN_ADDU:  control_s = CTL_ADDU;
                    FN_SUBU:  control_s = CTL_SUBU;
                    FN_AND:   control_s = CTL_AND;
                    FN_OR:    control_s = CTL_OR;
                    FN_XOR:   control_s = CTL_XOR;
                    FN_SLT:   control_s = CTL_SLT;
                    FN_SLTU:  control_s = CTL_SLTU;
                    FN_MULT:  control_s = CTL_MULT;
                    FN_MULTU: control_s = CTL_MULTU;
                    FN_DIV:   control_s = CTL_DIV;
                    FN_DIVU:  control_s = CTL_DIVU;
                    FN_MFHI:  control_s = CTL_MFHI;
                    FN_MFLO:  control_s = CTL_MFLO;
                    default:  control_s = CTL_AND;
                endcase
            end
            OPC_ADDIU: control_s = CTL_ADDU;
            OPC_ANDI:  control_s = CTL_AND;
            OPC_ORI:   control_s = CTL_OR;
            OPC_SLTI:  control_s = CTL_SLT;
            OPC_SLTIU: control_s = CTL_SLTU;
            default:   control_s = CTL_AND;
        endcase
    end

    // Classify the EX instruction; only md and HI/LO reads interact with the sequencer
    always_comb begin
        md_op_s = valid && (op == ALUOP_RTYPE) && is_md_funct(funct);
        hl_rd_s = valid && (op == ALUOP_RTYPE) && is_hl_funct(funct);
    end

    md_seq_core #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_op_s),
        .kind  (md_kind_e'(funct[1:0])),
        .a     (rs_val),
        .b     (rt_val),
        .busy  (busy_s),
        .done  (md_done),
        .hi    (hi),
        .lo    (lo)
    );

    assign control = control_s;
    assign stall   = (md_op_s || hl_rd_s) && busy_s;
    assign md_busy = busy_s;

endmodule

// File: tb/tb_alu_md_control.sv
// Self-checking bench for alu_md_control (W=32): decode sweep, md results via
// a scoreboard fed by an arithmetic reference model, stall handshake, reset.
module tb_alu_md_control;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         valid;
    logic [5:0]   op;
    logic [5:0]   funct;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic [3:0]   control;
    logic         stall;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         md_busy;
    logic         md_done;

    int checks;
    int errors;

    logic [63:0] sb_q[$];

    typedef struct packed {
        logic       v;
        logic [5:0] op;
        logic [5:0] fn;
        logic [3:0] ctl;
    } dec_vec_t;

    alu_md_control #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (valid),
        .op      (op),
        .funct   (funct),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .control (control),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo),
        .md_busy (md_busy),
        .md_done (md_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: returns {hi, lo}
    function automatic logic [63:0] md_model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint sq;
        longint sr;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 64'd0;
        case (fn)
            6'b011000: r = sa * sb;
            6'b011001: r = {32'd0, a} * {32'd0, b};
            6'b011010: begin
                if (b == 32'd0) begin
                    r = {a, (a[31] ? 32'd1 : 32'hFFFFFFFF)};
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {sr[31:0], sq[31:0]};
                end
            end
            6'b011011: begin
                if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                else            r = {a % b, a / b};
            end
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // Issue one md instruction, push its expectation, wait (bounded) for md_done
    task automatic run_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cnt, output logic [31:0] hi_o, output logic [31:0] lo_o);
        @(posedge clk); #1;
        valid = 1'b1; op = 6'b000010; funct = fn; rs_val = a; rt_val = b;
        sb_q.push_back(md_model(fn, a, b));
        @(posedge clk); #1;
        valid = 1'b0; op = 6'b000000; funct = 6'b000000; rs_val = 32'd0; rt_val = 32'd0;
        lat = 0; busy_cnt = 0; hi_o = 32'd0; lo_o = 32'd0;
        for (int i = 1; i <= 48 && lat == 0; i++) begin
            @(negedge clk);
            if (md_busy) busy_cnt++;
            if (md_done) begin
                lat = i; hi_o = hi; lo_o = lo;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b0; op = 6'b000000; funct = 6'b000000; rs_val = 32'd0; rt_val = 32'd0;
        repeat (3) @(negedge clk);
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", md_busy); end
        checks++; if (md_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", md_done); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        dec_vec_t vecs[$];
        vecs.push_back({1'b1, 6'b000000, 6'b100100, 4'b0010});
        vecs.push_back({1'b1, 6'b000001, 6'b011000, 4'b0110});
        vecs.push_back({1'b1, 6'b000010, 6'b100001, 4'b0100});
        vecs.push_back({1'b1, 6'b000010, 6'b100011, 4'b0101});
        vecs.push_back({1'b1, 6'b000010, 6'b100100, 4'b0000});
        vecs.push_back({1'b1, 6'b000010, 6'b100101, 4'b0001});
        vecs.push_back({1'b1, 6'b000010, 6'b100110, 4'b0011});
        vecs.push_back({1'b1, 6'b000010, 6'b101010, 4'b0111});
        vecs.push_back({1'b1, 6'b000010, 6'b101011, 4'b1010});
        vecs.push_back({1'b0, 6'b000010, 6'b011000, 4'b1000});
        vecs.push_back({1'b0, 6'b000010, 6'b011001, 4'b1001});
        vecs.push_back({1'b0, 6'b000010, 6'b011010, 4'b1011});
        vecs.push_back({1'b0, 6'b000010, 6'b011011, 4'b1100});
        vecs.push_back({1'b1, 6'b000010, 6'b010000, 4'b1101});
        vecs.push_back({1'b1, 6'b000010, 6'b010010, 4'b1110});
        vecs.push_back({1'b1, 6'b000010, 6'b111111, 4'b0000});
        vecs.push_back({1'b1, 6'b001001, 6'b000000, 4'b0100});
        vecs.push_back({1'b1, 6'b001100, 6'b000000, 4'b0000});
        vecs.push_back({1'b1, 6'b001101, 6'b000000, 4'b0001});
        vecs.push_back({1'b1, 6'b001010, 6'b000000, 4'b0111});
        vecs.push_back({1'b1, 6'b001011, 6'b000000, 4'b1010});
        foreach (vecs[k]) begin
            @(posedge clk); #1;
            valid = vecs[k].v; op = vecs[k].op; funct = vecs[k].fn;
            @(negedge clk);
            checks++;
            if (control !== vecs[k].ctl) begin
                errors++; $display("FAIL decode_%0d op=%b funct=%b got=%b exp=%b", k, vecs[k].op, vecs[k].fn, control, vecs[k].ctl);
            end
            checks++;
            if (stall !== 1'b0) begin errors++; $display("FAIL decode_stall_%0d got=%b exp=0", k, stall); end
        end
        @(posedge clk); #1;
        valid = 1'b0; op = 6'b000000; funct = 6'b000000;
        @(negedge clk);
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL decode_no_start got=%b exp=0", md_busy); end
    endtask

    task automatic test_multu_max();
        int lat; int bc; logic [31:0] h; logic [31:0] l; logic [63:0] exp;
        run_md(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, h, l);
        exp = sb_q.pop_front();
        checks++; if (lat !== 34) begin errors++; $display("FAIL multu_latency got=%0d exp=34", lat); end
        checks++; if (bc !== 33) begin errors++; $display("FAIL multu_busy_cycles got=%0d exp=33", bc); end
        checks++; if (h !== exp[63:32]) begin errors++; $display("FAIL multu_hi got=%h exp=%h", h, exp[63:32]); end
        checks++; if (l !== exp[31:0]) begin errors++; $display("FAIL multu_lo got=%h exp=%h", l, exp[31:0]); end
        @(negedge clk);
        checks++; if (md_done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got=%b exp=0", md_done); end
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL multu_idle got=%b exp=0", md_busy); end
    endtask

    task automatic test_arith();
        logic [5:0]  fns[$];
        logic [31:0] as[$];
        logic [31:0] bs[$];
        int lat; int bc; logic [31:0] h; logic [31:0] l; logic [63:0] exp;
        fns = '{6'b011000, 6'b011010, 6'b011011, 6'b011010, 6'b011010, 6'b011011, 6'b011000};
        as  = '{32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd7, 32'hFFFFFFFF, 32'h7FFFFFFF};
        bs  = '{32'd5, 32'd2, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd16, 32'h80000000};
        foreach (fns[k]) begin
            run_md(fns[k], as[k], bs[k], lat, bc, h, l);
            exp = sb_q.pop_front();
            checks++; if (lat !== 34) begin errors++; $display("FAIL arith_%0d_latency got=%0d exp=34", k, lat); end
            checks++;
            if ({h, l} !== exp) begin
                errors++; $display("FAIL arith_%0d funct=%b a=%h b=%h got hi=%h lo=%h exp hi=%h lo=%h", k, fns[k], as[k], bs[k], h, l, exp[63:32], exp[31:0]);
            end
        end
    endtask

    task automatic test_stall();
        logic [63:0] exp; int stall_cnt; logic released;
        @(posedge clk); #1;
        valid = 1'b1; op = 6'b000010; funct = 6'b011000; rs_val = 32'd123; rt_val = 32'hFFFFFE38;
        sb_q.push_back(md_model(6'b011000, 32'd123, 32'hFFFFFE38));
        @(posedge clk); #1;
        funct = 6'b100001; rs_val = 32'd1; rt_val = 32'd2;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL add_during_run_stall got=%b exp=0", stall); end
        checks++; if (control !== 4'b0100) begin errors++; $display("FAIL add_during_run_ctl got=%b exp=0100", control); end
        checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL run_busy got=%b exp=1", md_busy); end
        @(posedge clk); #1;
        valid = 1'b0;
        @(posedge clk); #1;
        valid = 1'b1; funct = 6'b010000;
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mfhi_stall got=%b exp=1", stall); end
        checks++; if (control !== 4'b1101) begin errors++; $display("FAIL mfhi_ctl got=%b exp=1101", control); end
        stall_cnt = stall ? 1 : 0;
        released = 1'b0;
        for (int i = 0; i < 48 && !released; i++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            else released = 1'b1;
        end
        exp = sb_q.pop_front();
        checks++; if (released !== 1'b1) begin errors++; $display("FAIL mfhi_release got=%b exp=1", released); end
        checks++; if (stall_cnt !== 31) begin errors++; $display("FAIL mfhi_stall_cycles got=%0d exp=31", stall_cnt); end
        checks++; if (md_done !== 1'b1) begin errors++; $display("FAIL mfhi_release_done got=%b exp=1", md_done); end
        checks++; if (hi !== exp[63:32]) begin errors++; $display("FAIL mfhi_new_hi got=%h exp=%h", hi, exp[63:32]); end
        checks++; if (lo !== exp[31:0]) begin errors++; $display("FAIL mfhi_new_lo got=%h exp=%h", lo, exp[31:0]); end
        @(posedge clk); #1;
        valid = 1'b0; op = 6'b000000; funct = 6'b000000;
    endtask

    task automatic test_reset_midrun();
        logic done_seen; int lat; int bc; logic [31:0] h; logic [31:0] l; logic [63:0] exp;
        @(posedge clk); #1;
        valid = 1'b1; op = 6'b000010; funct = 6'b011001; rs_val = 32'hFFFFFFFF; rt_val = 32'd3;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got=%b exp=1", md_busy); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL midrun_rst_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL midrun_rst_lo got=%h exp=0", lo); end
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL midrun_rst_busy got=%b exp=0", md_busy); end
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            if (md_done || md_busy) done_seen = 1'b1;
        end
        checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL midrun_discarded got=%b exp=0", done_seen); end
        run_md(6'b011001, 32'd6, 32'd7, lat, bc, h, l);
        exp = sb_q.pop_front();
        checks++; if (lat !== 34) begin errors++; $display("FAIL post_rst_latency got=%0d exp=34", lat); end
        checks++; if (l !== exp[31:0]) begin errors++; $display("FAIL post_rst_lo got=%h exp=%h", l, exp[31:0]); end
        checks++; if (h !== exp[63:32]) begin errors++; $display("FAIL post_rst_hi got=%h exp=%h", h, exp[63:32]); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_decode();
        test_multu_max();
        test_arith();
        test_stall();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_md_control.md
Name: alu_md_control

Overview:
- Parametrised successor to the single-cycle ALU control decoder.
- Decodes the ALUOp/funct pair from main control into the 4-bit ALU control code.
- Adds a multi-cycle multiply/divide sequencer with HI/LO registers, a busy FSM and a pipeline stall handshake, so mult/multu/div/divu/mfhi/mflo execute correctly in the MIPS datapath.
- Sits between main control / register-file read and the ALU / writeback mux.

Parameters:
- W, 32, operand/HI/LO width (≥4, even).
- CNT_W, $clog2(W)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid  in  1  instruction in EX is real (not a bubble)
- op  in  6  ALUOp from main control (ADD=000000, SUB=000001, RTYPE=000010, else I-type opcode)
- funct  in  6  instruction funct field
- rs_val  in  W  operand A / dividend / multiplicand
- rt_val  in  W  operand B / divisor / multiplier
- control  out  4  ALU control code (combinational)
- stall  out  1  hold PC/IF/ID/EX this cycle (combinational)
- hi  out  W  HI register
- lo  out  W  LO register
- md_busy  out  1  sequencer not IDLE
- md_done  out  1  one-cycle pulse: HI/LO just updated

Behaviour:
- Decode, combinational:
  - ADD/addu/addiu → 0010/0100/0100
  - SUB/subu → 0110/0101
  - and/andi → 0000; or/ori → 0001; xor → 0011
  - slt/slti → 0111; sltu/sltiu → 1010
  - mult → 1000; multu → 1001; div → 1011; divu → 1100
  - mfhi → 1101; mflo → 1110
  - anything else → 0000
  - Each funct code maps to exactly one code; no duplicate decode arms.
- md op = valid && op==RTYPE && funct ∈ {011000 mult, 011001 multu, 011010 div, 011011 divu}.
- hl read = valid && op==RTYPE && funct ∈ {010000 mfhi, 010010 mflo}.
- FSM states: IDLE, RUN, FIX.
  - IDLE: md op → latch |A|,|B| (magnitudes for signed ops, raw for unsigned), result sign, remainder sign, kind; count=W; go to RUN. Stall is not asserted on the accept cycle.
  - RUN: one radix-2 step per cycle.
    - Multiply: shift-add into a 2W accumulator.
    - Divide: restoring shift-subtract.
    - count decrements; at count==1 → FIX.
  - FIX: apply signs.
    - Product: 2's complement if the signs differ.
    - Quotient: negated if the signs differ.
    - Remainder: takes the dividend's sign.
    - Write hi/lo at the clock edge leaving FIX; → IDLE; md_done=1 the following cycle.
- Latency: accept edge t0 → hi/lo valid and md_done high in cycle t0+W+2. md_busy is high from t0+1 through t0+W+1.
- stall = valid && (md op || hl read) && state≠IDLE. The requester holds its instruction; it is accepted on the first IDLE cycle.
- mfhi/mflo in the md_done cycle read the new values; no stall.
- Divide by zero: no trap. lo = all-ones (unsigned) or quotient sign-fixed per the rules above; hi = dividend (rs_val unmodified).
- Signed overflow (div −2^(W−1) / −1): lo = −2^(W−1), hi = 0; no trap.
- Reset (any time, including mid-RUN):
  - state=IDLE; hi=lo=0; md_busy=0; md_done=0; counters and datapath registers 0.
  - The operation in progress is discarded.
- Non-md instructions decode normally while the sequencer is busy. Only md and hl instructions stall.

Decomposition:
- Shared package/header alu_defs:
  - ALUOp constants (ADD, SUB, RTYPE)
  - funct constants
  - 4-bit ALU control codes
  - FSM state encoding
- Natural sub-module: md_seq_core, holding the FSM, counter, accumulator/remainder datapath and sign fix-up.
- The decoder and stall logic stay in alu_md_control.

Test Plan:
- Decode sweep: every listed op/funct pair → the listed control code; op=000010 funct=111111 → 0000; no stall asserted.
- multu 0xFFFFFFFF × 0xFFFFFFFF (W=32) → after 34 cycles: hi=0xFFFFFFFE, lo=0x00000001, md_done pulses once.
- mult −3 × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; div −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 100 / 0 → lo=0xFFFFFFFF, hi=100; div 0x80000000 / −1 → lo=0x80000000, hi=0.
- mfhi issued 3 cycles after mult accept → stall=1 until IDLE; released in the md_done cycle with the new hi readable. An add issued during RUN is never stalled.
- rst_n low for one cycle mid-RUN → immediately hi=lo=0, md_busy=0. A following multu 6 × 7 → lo=42, hi=0.
